// File: rtl/adas_pkg.sv
// Shared defaults and sizing helper for the ADAS brake-decision block.
package adas_pkg;

  localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
  localparam int unsigned DEFAULT_CONFIRM_CYCLES = 4;

  // Bits needed to hold a count from 0 up to and including max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with synchronous active-high clear.
module sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/adas_brake_ctrl.sv
// Brake decision: driver pedal OR confirmed camera+radar obstacle, with the
// autonomous branch disabled by the ADAS error flag.
module adas_brake_ctrl
  import adas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int unsigned CONFIRM_CYCLES = DEFAULT_CONFIRM_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic driver_break,
  input  logic camera,
  input  logic radar,
  input  logic adas_error,
  output logic vehicle_break,
  output logic auto_brake,
  output logic fault
);

  localparam int unsigned   CW       = cnt_width(CONFIRM_CYCLES);
  localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM_CYCLES);

  logic d_s, c_s, r_s, e_s;
  logic det, confirmed, confirmed_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vb_q, vb_d, ab_q, ab_d, flt_q, flt_d;

  sync_bit #(.N(SYNC_STAGES)) u_sync_drv (
    .clock_i(clock), .reset_i(reset), .d_i(driver_break), .q_o(d_s)
  );
  sync_bit #(.N(SYNC_STAGES)) u_sync_cam (
    .clock_i(clock), .reset_i(reset), .d_i(camera), .q_o(c_s)
  );
  sync_bit #(.N(SYNC_STAGES)) u_sync_rad (
    .clock_i(clock), .reset_i(reset), .d_i(radar), .q_o(r_s)
  );
  sync_bit #(.N(SYNC_STAGES)) u_sync_err (
    .clock_i(clock), .reset_i(reset), .d_i(adas_error), .q_o(e_s)
  );

  assign det       = c_s & r_s & ~e_s;
  assign confirmed = (cnt_q == CONF_MAX);

  // Outputs look at the count being written this edge, so the autonomous
  // brake asserts on the same edge the count reaches CONFIRM_CYCLES.
  always_comb begin
    cnt_d = '0;
    if (det) begin
      cnt_d = confirmed ? cnt_q : cnt_q + 1'b1;
    end
    confirmed_next = (cnt_d == CONF_MAX);
    ab_d           = det & confirmed_next;
    vb_d           = d_s | ab_d;
    flt_d          = e_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      vb_q  <= 1'b0;
      ab_q  <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vb_q  <= vb_d;
      ab_q  <= ab_d;
      flt_q <= flt_d;
    end
  end

  assign vehicle_break = vb_q;
  assign auto_brake    = ab_q;
  assign fault         = flt_q;

endmodule

// File: tb/tb_adas_brake_ctrl.sv
// Self-checking bench for adas_brake_ctrl at default parameters.
module tb_adas_brake_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic driver_break, camera, radar, adas_error;
  logic vehicle_break, auto_brake, fault;

  typedef struct {
    int unsigned tgt;
    logic [2:0]  exp;   // {vehicle_break, auto_brake, fault}
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0] in;     // {driver_break, camera, radar, adas_error}
    logic       vb, ab, f;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[16];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  adas_brake_ctrl dut (
    .clock(clock), .reset(reset),
    .driver_break(driver_break), .camera(camera), .radar(radar),
    .adas_error(adas_error),
    .vehicle_break(vehicle_break), .auto_brake(auto_brake), .fault(fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard drain: outputs are sampled on the falling edge.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tgt <= cyc) begin
        n_cmp++;
        if (sb[i].tgt < cyc || {vehicle_break, auto_brake, fault} !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s @edge %0d: vb/ab/fault got %b expected %b",
                   sb[i].name, sb[i].tgt, {vehicle_break, auto_brake, fault}, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic [3:0] v);
    {driver_break, camera, radar, adas_error} = v;
  endtask

  task automatic expect_out(input int unsigned dly, input logic vb, input logic ab,
                            input logic f, input string nm);
    exp_t e;
    e.tgt  = cyc + dly;
    e.exp  = {vb, ab, f};
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic settle(input logic [3:0] v);
    drive(v);
    repeat (12) @(negedge clock);
  endtask

  initial begin
    logic [15:0] vb_mask = 16'hFF40;  // 0110 and 1xxx brake
    logic [15:0] ab_mask = 16'h4040;  // only 0110 and 1110 brake autonomously
    for (int i = 0; i < 16; i++) begin
      vecs[i].in = 4'(i);
      vecs[i].vb = vb_mask[i];
      vecs[i].ab = ab_mask[i];
      vecs[i].f  = vecs[i].in[0];
    end

    // Reset with all inputs high, then release with pedal + obstacle.
    reset = 1'b1;
    drive(4'b1111);
    for (int unsigned k = 1; k <= 3; k++) expect_out(k, 0, 0, 0, "reset_hold");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive(4'b1110);
    expect_out(2, 0, 0, 0, "rel_vb_e2");
    expect_out(3, 1, 0, 0, "rel_vb_e3");
    expect_out(5, 1, 0, 0, "rel_ab_e5");
    expect_out(6, 1, 1, 0, "rel_ab_e6");
    repeat (8) @(negedge clock);

    // Exhaustive sweep, checked in the last cycle of each 10-cycle hold.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].in);
      expect_out(10, vecs[i].vb, vecs[i].ab, vecs[i].f, $sformatf("sweep_%0d", i));
      repeat (10) @(negedge clock);
    end

    // Driver latency, both directions.
    settle(4'b0000);
    drive(4'b1000);
    expect_out(2, 0, 0, 0, "drv_on_e2");
    expect_out(3, 1, 0, 0, "drv_on_e3");
    repeat (6) @(negedge clock);
    drive(4'b0000);
    expect_out(2, 1, 0, 0, "drv_off_e2");
    expect_out(3, 0, 0, 0, "drv_off_e3");
    repeat (6) @(negedge clock);

    // Three-cycle coincidence must never brake.
    settle(4'b0000);
    drive(4'b0110);
    for (int unsigned k = 1; k <= 10; k++) expect_out(k, 0, 0, 0, "glitch3");
    repeat (3) @(negedge clock);
    drive(4'b0100);
    repeat (9) @(negedge clock);

    // Four-cycle coincidence brakes for exactly one edge.
    settle(4'b0000);
    drive(4'b0110);
    expect_out(5, 0, 0, 0, "hold4_e5");
    expect_out(6, 1, 1, 0, "hold4_e6");
    expect_out(7, 0, 0, 0, "hold4_e7");
    repeat (4) @(negedge clock);
    drive(4'b0100);
    repeat (6) @(negedge clock);

    // Error override while braking, then driver still brakes.
    settle(4'b0110);
    drive(4'b0111);
    expect_out(2, 1, 1, 0, "err_e2");
    expect_out(3, 0, 0, 1, "err_e3");
    repeat (6) @(negedge clock);
    drive(4'b1111);
    expect_out(2, 0, 0, 1, "err_drv_e2");
    expect_out(3, 1, 0, 1, "err_drv_e3");
    repeat (6) @(negedge clock);

    // One-cycle reset mid-braking, then pipeline refill.
    settle(4'b0110);
    reset = 1'b1;
    expect_out(1, 0, 0, 0, "midrst_edge");
    for (int unsigned k = 2; k <= 6; k++) expect_out(k, 0, 0, 0, "midrst_refill");
    expect_out(7, 1, 1, 0, "midrst_reassert");
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
